// File: rtl/psum_drain.sv
// Drains psum rows from the output FIFO into SRAM, either overwriting the
// target rows or accumulating onto them (per-column wrap-around add).
module psum_drain #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11,
  parameter int len_bw  = 11,
  parameter int rd_lat  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     acc,
  input  logic [addr_bw-1:0]       base_addr,
  input  logic [len_bw-1:0]        len,
  input  logic                     ofifo_valid,
  output logic                     ofifo_rd,
  input  logic [psum_bw*col-1:0]   ofifo_out,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [addr_bw-1:0]       sram_addr,
  output logic [psum_bw*col-1:0]   sram_d,
  input  logic [psum_bw*col-1:0]   sram_q,
  output logic                     busy,
  output logic                     done
);

  localparam int dw      = psum_bw * col;
  localparam int wait_bw = $clog2(rd_lat + 1);

  typedef enum logic [2:0] {
    s_idle, s_issue, s_wait, s_load, s_add, s_write, s_done
  } state_t;

  state_t               state, state_next;
  logic                 acc_q;
  logic [addr_bw-1:0]   base_q;
  logic [len_bw-1:0]    len_q;
  logic [len_bw-1:0]    row_cnt;
  logic [len_bw-1:0]    row_inc;
  logic [wait_bw-1:0]   wait_cnt;
  logic [dw-1:0]        row_q;
  logic [dw-1:0]        sum_q;
  logic [dw-1:0]        sum_next;
  logic [addr_bw-1:0]   row_addr;

  assign row_addr = base_q + addr_bw'(row_cnt);
  assign row_inc  = row_cnt + len_bw'(1);

  always_comb begin
    sum_next = '0;
    for (int i = 0; i < col; i++)
      sum_next[i*psum_bw +: psum_bw] = sram_q[i*psum_bw +: psum_bw] + row_q[i*psum_bw +: psum_bw];
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= s_idle;
    else        state <= state_next;
  end

  // ofifo handshake: a row is popped only in a cycle where ofifo_valid=1 and
  // ofifo_rd=1; the popped row appears on ofifo_out rd_lat cycles later.
  always_comb begin
    state_next = state;
    ofifo_rd   = 1'b0;
    sram_cen   = 1'b1;
    sram_wen   = 1'b1;
    sram_addr  = '0;
    sram_d     = '0;
    busy       = (state != s_idle);
    done       = 1'b0;
    case (state)
      s_idle: begin
        if (start) state_next = (len != '0) ? s_issue : s_done;
      end
      s_issue: begin
        if (ofifo_valid) begin
          ofifo_rd   = 1'b1;
          state_next = s_wait;
        end
      end
      s_wait: begin
        if (wait_cnt == wait_bw'(1)) state_next = acc_q ? s_load : s_write;
      end
      s_load: begin
        sram_cen   = 1'b0;
        sram_addr  = row_addr;
        state_next = s_add;
      end
      s_add: state_next = s_write;
      s_write: begin
        sram_cen   = 1'b0;
        sram_wen   = 1'b0;
        sram_addr  = row_addr;
        sram_d     = acc_q ? sum_q : row_q;
        state_next = (row_inc == len_q) ? s_done : s_issue;
      end
      s_done: begin
        done       = 1'b1;
        state_next = s_idle;
      end
      default: state_next = s_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q    <= 1'b0;
      base_q   <= '0;
      len_q    <= '0;
      row_cnt  <= '0;
      wait_cnt <= '0;
      row_q    <= '0;
      sum_q    <= '0;
    end else begin
      case (state)
        s_idle: begin
          if (start && len != '0) begin
            acc_q   <= acc;
            base_q  <= base_addr;
            len_q   <= len;
            row_cnt <= '0;
          end
        end
        s_issue: if (ofifo_valid) wait_cnt <= wait_bw'(rd_lat);
        s_wait: begin
          wait_cnt <= wait_cnt - wait_bw'(1);
          if (wait_cnt == wait_bw'(1)) row_q <= ofifo_out;
        end
        s_add:   sum_q   <= sum_next;
        s_write: row_cnt <= row_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// Bench for psum_drain: FIFO and SRAM models, a job-level reference model that
// predicts every SRAM read/write, and directed timing/boundary checks.
module tb_psum_drain;
  localparam int COL    = 8;
  localparam int PBW    = 16;
  localparam int ABW    = 11;
  localparam int LBW    = 11;
  localparam int RD_LAT = 1;
  localparam int DW     = COL * PBW;
  localparam int W      = ABW + DW;
  localparam int DEPTH  = 1 << ABW;

  logic clk = 1'b0;
  logic reset, start, acc, ofifo_valid;
  logic [ABW-1:0] base_addr;
  logic [LBW-1:0] len;
  logic [DW-1:0]  ofifo_out, sram_q, sram_d;
  logic ofifo_rd, sram_cen, sram_wen, busy, done;
  logic [ABW-1:0] sram_addr;

  always #5 clk = ~clk;

  psum_drain #(.col(COL), .psum_bw(PBW), .addr_bw(ABW), .len_bw(LBW), .rd_lat(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .acc(acc), .base_addr(base_addr), .len(len),
    .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd), .ofifo_out(ofifo_out),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_d(sram_d),
    .sram_q(sram_q), .busy(busy), .done(done)
  );

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;

  logic [DW-1:0]  sram      [DEPTH];
  logic [DW-1:0]  model_mem [DEPTH];
  logic [DW-1:0]  pipe      [RD_LAT];
  logic [DW-1:0]  fifo_q[$];
  logic [W-1:0]   exp_q[$];
  logic [ABW-1:0] exp_rd_q[$];
  int fifo_idx = 0, exp_idx = 0, rdq_idx = 0;
  int rd_total = 0, wr_total = 0, sr_total = 0, done_total = 0;
  int rd_at[4096], wr_at[4096], done_at[4096];
  bit stall = 1'b0, rand_valid = 1'b0;
  logic           poke_req = 1'b0;
  logic [ABW-1:0] poke_addr = '0;
  logic [DW-1:0]  poke_data = '0;

  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] r;
    for (int c = 0; c < COL; c++) r[c*PBW +: PBW] = PBW'($urandom);
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
    end
  endtask

  // ---------------- clock/cycle counter and SRAM model
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (poke_req) sram[poke_addr] <= poke_data;
    else if (!sram_cen && !sram_wen) sram[sram_addr] <= sram_d;
    if (!sram_cen && sram_wen) sram_q <= sram[sram_addr];
  end

  // ---------------- ofifo model: rows pop on rd, show up RD_LAT cycles later
  always @(posedge clk) begin
    pipe[0] <= rand_row();
    if (!reset) fifo_idx <= fifo_q.size();
    else if (ofifo_rd && fifo_idx < fifo_q.size()) begin
      pipe[0]  <= fifo_q[fifo_idx];
      fifo_idx <= fifo_idx + 1;
    end
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign ofifo_out = pipe[RD_LAT-1];

  always @(posedge clk) begin
    #1;
    ofifo_valid = (fifo_idx < fifo_q.size()) && !stall &&
                  (!rand_valid || ($urandom_range(0, 3) != 0));
  end

  // ---------------- compare process
  always @(negedge clk) begin
    if (!reset) begin
      exp_idx = exp_q.size();
      rdq_idx = exp_rd_q.size();
    end else begin
      if (!sram_cen && !sram_wen) begin
        check("write_pending", 256'(exp_idx < exp_q.size()), 256'(1));
        if (exp_idx < exp_q.size()) begin
          check("sram_write", 256'({sram_addr, sram_d}), 256'(exp_q[exp_idx]));
          exp_idx++;
        end
        wr_at[wr_total] = cyc;
        wr_total++;
      end else if (!sram_cen && sram_wen) begin
        check("read_pending", 256'(rdq_idx < exp_rd_q.size()), 256'(1));
        if (rdq_idx < exp_rd_q.size()) begin
          check("sram_read_addr", 256'(sram_addr), 256'(exp_rd_q[rdq_idx]));
          rdq_idx++;
        end
        sr_total++;
      end else begin
        check("idle_sram_outputs", 256'({sram_wen, sram_addr, sram_d}), 256'({1'b1, {ABW{1'b0}}, {DW{1'b0}}}));
      end
      if (ofifo_rd) begin
        check("rd_needs_valid", 256'(ofifo_valid), 256'(1));
        rd_at[rd_total] = cyc;
        rd_total++;
      end
      if (done) begin
        check("done_while_busy", 256'(busy), 256'(1));
        done_at[done_total] = cyc;
        done_total++;
      end
    end
  end

  // ---------------- driver tasks
  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic poke(input logic [ABW-1:0] a, input logic [DW-1:0] v);
    @(posedge clk); #2;
    poke_req = 1'b1; poke_addr = a; poke_data = v;
  endtask

  task automatic poke_end();
    @(posedge clk); #2;
    poke_req = 1'b0;
  endtask

  // row_mode: 0 random, 1 every column = row index + 1, 2 col0 = 1 others 0
  task automatic launch_job(input bit a, input logic [ABW-1:0] b, input int n, input int row_mode);
    logic [ABW-1:0] addr;
    logic [DW-1:0]  row, data;
    int s;
    for (int r = 0; r < n; r++) begin
      addr = b + ABW'(r);
      case (row_mode)
        1:       row = {COL{PBW'(r + 1)}};
        2:       row = DW'(1);
        default: row = rand_row();
      endcase
      if (a) begin
        exp_rd_q.push_back(addr);
        for (int c = 0; c < COL; c++) begin
          s = int'(model_mem[addr][c*PBW +: PBW]) + int'(row[c*PBW +: PBW]);
          data[c*PBW +: PBW] = s[PBW-1:0];
        end
      end else data = row;
      model_mem[addr] = data;
      exp_q.push_back({addr, data});
      fifo_q.push_back(row);
    end
    @(posedge clk); #2;
    acc = a; base_addr = b; len = LBW'(n); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; acc = 1'($urandom); base_addr = ABW'($urandom); len = LBW'($urandom);
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k = 0;
    while (done_total == d0 && k < budget) begin
      wait_neg();
      k++;
    end
    check("done_seen", 256'(done_total > d0), 256'(1));
  endtask

  task automatic run_job(input bit a, input logic [ABW-1:0] b, input int n, input int row_mode);
    int d0 = done_total;
    launch_job(a, b, n, row_mode);
    wait_done(d0, 40 * n + 20);
    wait_neg();
    check("writes_drained", 256'(exp_q.size() - exp_idx), 256'(0));
    check("reads_drained", 256'(exp_rd_q.size() - rdq_idx), 256'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0, d0, s0, n;
    logic [DW-1:0] v;
    logic [DW-PBW-1:0] upper;
    logic [ABW-1:0] b;
    logic [ABW-1:0] save_a [2];
    logic [DW-1:0]  save_v [2];

    // ---------------- reset
    reset = 1'b0; start = 1'b0; acc = 1'b0; base_addr = '0; len = '0;
    repeat (3) @(posedge clk);
    wait_neg();
    check("reset_outputs", 256'({ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d, busy, done}),
          256'({1'b0, 1'b1, 1'b1, {ABW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b0}));
    @(posedge clk); #2;
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      v = rand_row();
      model_mem[i] = v;
      poke(ABW'(i), v);
    end
    poke_end();

    // ---------------- overwrite, 3 rows at 4..6
    r0 = rd_total; w0 = wr_total;
    run_job(1'b0, ABW'(4), 3, 1);
    check("ovw_rd_count", 256'(rd_total - r0), 256'(3));
    check("ovw_rd_gap0", 256'(rd_at[r0+1] - rd_at[r0]), 256'(3));
    check("ovw_rd_gap1", 256'(rd_at[r0+2] - rd_at[r0+1]), 256'(3));
    check("ovw_rd_to_wr", 256'(wr_at[w0] - rd_at[r0]), 256'(RD_LAT + 1));
    check("ovw_done_after_wr", 256'(done_at[done_total-1] - wr_at[wr_total-1]), 256'(1));
    check("ovw_mem4", 256'(sram[4]), 256'({COL{16'h0001}}));
    check("ovw_mem6", 256'(sram[6]), 256'({COL{16'h0003}}));

    // ---------------- accumulate with column wrap
    v = model_mem[10];
    v[PBW-1:0] = 16'h7FFF;
    upper = v[DW-1:PBW];
    model_mem[10] = v;
    poke(ABW'(10), v);
    poke_end();
    s0 = sr_total;
    run_job(1'b1, ABW'(10), 1, 2);
    check("acc_reads", 256'(sr_total - s0), 256'(1));
    check("acc_col0_wrap", 256'(sram[10][PBW-1:0]), 256'(16'h8000));
    check("acc_upper_kept", 256'(sram[10][DW-1:PBW]), 256'(upper));
    r0 = rd_total;
    run_job(1'b1, ABW'(100), 3, 0);
    check("acc_rd_gap", 256'(rd_at[r0+1] - rd_at[r0]), 256'(RD_LAT + 4));

    // ---------------- stall in ISSUE
    stall = 1'b1;
    d0 = done_total; w0 = wr_total;
    launch_job(1'b0, ABW'(50), 1, 0);
    for (int i = 0; i < 5; i++) begin
      wait_neg();
      check("stall_quiet", 256'({ofifo_rd, sram_cen, busy}), 256'(3'b011));
    end
    stall = 1'b0;
    wait_neg();
    check("stall_resume", 256'({ofifo_valid, ofifo_rd}), 256'(2'b11));
    wait_done(d0, 20);
    check("stall_write", 256'(wr_total - w0), 256'(1));

    // ---------------- len = 0
    d0 = done_total; r0 = rd_total; w0 = wr_total; s0 = sr_total;
    launch_job(1'b1, ABW'(7), 0, 0);
    wait_done(d0, 2);
    check("len0_no_access", 256'({rd_total - r0, wr_total - w0, sr_total - s0}), 256'(0));

    // ---------------- address wrap
    run_job(1'b0, ABW'(2047), 2, 1);
    check("wrap_mem2047", 256'(sram[2047]), 256'({COL{16'h0001}}));
    check("wrap_mem0", 256'(sram[0]), 256'({COL{16'h0002}}));
    run_job(1'b1, ABW'(2046), 4, 0);

    // ---------------- start while busy is ignored
    d0 = done_total; r0 = rd_total;
    launch_job(1'b0, ABW'(200), 4, 0);
    @(posedge clk); #2;
    acc = 1'b1; base_addr = ABW'(500); len = LBW'(7); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(d0, 100);
    repeat (10) wait_neg();
    check("busy_start_done_count", 256'(done_total - d0), 256'(1));
    check("busy_start_rd_count", 256'(rd_total - r0), 256'(4));

    // ---------------- reset during WAIT of row 2
    for (int i = 0; i < 2; i++) begin
      save_a[i] = ABW'(302 + i);
      save_v[i] = model_mem[302 + i];
    end
    d0 = done_total; r0 = rd_total; w0 = wr_total;
    launch_job(1'b0, ABW'(300), 4, 0);
    n = 0;
    while (rd_total - r0 < 3 && n < 100) begin
      wait_neg();
      n++;
    end
    check("mid_reset_reached_row2", 256'(rd_total - r0), 256'(3));
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;
    @(negedge clk); #1;
    check("mid_reset_outputs", 256'({ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d, busy, done}),
          256'({1'b0, 1'b1, 1'b1, {ABW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b0}));
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (20) wait_neg();
    check("mid_reset_writes", 256'(wr_total - w0), 256'(2));
    check("mid_reset_rds", 256'(rd_total - r0), 256'(3));
    check("mid_reset_no_done", 256'(done_total - d0), 256'(0));
    for (int i = 0; i < 2; i++) model_mem[save_a[i]] = save_v[i];

    // ---------------- randomized jobs
    rand_valid = 1'b1;
    for (int j = 0; j < 25; j++) begin
      b = ($urandom_range(0, 3) == 0) ? ABW'($urandom_range(2042, 2047)) : ABW'($urandom_range(0, 2047));
      run_job(1'($urandom), b, $urandom_range(1, 6), 0);
    end
    rand_valid = 1'b0;

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
